cfg_chain_loader: RTL and testbench

- Sequences the fabric configuration chain, i.e. the serial chain of cfg_bit cells driven by a shared cfg_clk/cfg_value pair.
- Accepts a bitstream as bytes over a valid/ready interface and serialises exactly NUM_BITS bits onto the chain with a programmable cfg_clk period.
- Reports busy, done and overflow status.
- Sits between the host interface (UART/SPI front end) and the chain input of the cell array; replaces manual bit-banging of cfg_clk/cfg_value.

---
 rtl/cfg_chain_loader.sv | 172 +++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// Configuration-chain loader: accepts bitstream bytes over valid/ready and shifts
// exactly NUM_BITS bits LSB-first onto the cfg_clk/cfg_value serial chain.
module cfg_chain_loader #(
   parameter int NUM_BITS = 20,
   parameter int CLK_DIV  = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       abort_i,
   input  logic [7:0] data_i,
   input  logic       data_valid_i,
   output logic       data_ready_o,
   output logic       cfg_clk_o,
   output logic       cfg_value_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       overflow_o
);

   localparam int CNT_W = $clog2(NUM_BITS + 1);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [DIV_W-1:0] r_div_cnt;
   logic [2:0]       r_byte_bit;
   logic [7:0]       r_shift;
   logic             r_ready;
   logic             r_cfg_clk;
   logic             r_cfg_value;
   logic             r_busy;
   logic             r_done;
   logic             r_ovf;

   logic w_phase_end;
   logic w_accept;
   logic w_next_bit;

   assign w_phase_end = (r_div_cnt == DIV_LAST);
   assign w_accept    = (r_state == S_FETCH) && r_ready && data_valid_i && !abort_i;
   // Advance within the current byte only when more chain bits are still owed.
   assign w_next_bit  = (r_state == S_SHIFT_HI) && w_phase_end && !abort_i &&
                        (r_bit_cnt != LAST_BIT) && (r_byte_bit != 3'd7);

   // Byte shift register is pure data; its contents only matter after an accept.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_shift <= data_i;
      end else if (w_next_bit) begin
         r_shift <= {1'b0, r_shift[7:1]};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= '0;
         r_div_cnt   <= '0;
         r_byte_bit  <= '0;
         r_ready     <= 1'b0;
         r_cfg_clk   <= 1'b0;
         r_cfg_value <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  r_state     <= S_FETCH;
                  r_bit_cnt   <= '0;
                  r_div_cnt   <= '0;
                  r_ready     <= 1'b1;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_ovf       <= 1'b0;
                  r_cfg_clk   <= 1'b0;
                  r_cfg_value <= 1'b0;
               end else if ((r_state == S_DONE) && data_valid_i) begin
                  r_ovf <= 1'b1;
               end
            end

            S_FETCH: begin
               if (abort_i) begin
                  r_state     <= S_IDLE;
                  r_ready     <= 1'b0;
                  r_busy      <= 1'b0;
                  r_cfg_clk   <= 1'b0;
                  r_cfg_value <= 1'b0;
                  r_div_cnt   <= '0;
               end else if (w_accept) begin
                  r_state     <= S_SHIFT_LO;
                  r_ready     <= 1'b0;
                  r_cfg_value <= data_i[0];
                  r_byte_bit  <= '0;
                  r_div_cnt   <= '0;
               end
            end

            S_SHIFT_LO: begin
               if (abort_i) begin
                  r_state     <= S_IDLE;
                  r_busy      <= 1'b0;
                  r_cfg_clk   <= 1'b0;
                  r_cfg_value <= 1'b0;
                  r_div_cnt   <= '0;
               end else if (w_phase_end) begin
                  r_state   <= S_SHIFT_HI;
                  r_cfg_clk <= 1'b1;
                  r_div_cnt <= '0;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end

            S_SHIFT_HI: begin
               if (abort_i) begin
                  r_state     <= S_IDLE;
                  r_busy      <= 1'b0;
                  r_cfg_clk   <= 1'b0;
                  r_cfg_value <= 1'b0;
                  r_div_cnt   <= '0;
               end else if (w_phase_end) begin
                  r_cfg_clk <= 1'b0;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  r_div_cnt <= '0;
                  if (r_bit_cnt == LAST_BIT) begin
                     r_state     <= S_DONE;
                     r_done      <= 1'b1;
                     r_busy      <= 1'b0;
                     r_cfg_value <= 1'b0;
                  end else if (r_byte_bit != 3'd7) begin
                     // New bit appears on the falling edge, giving a full low phase of setup.
                     r_state     <= S_SHIFT_LO;
                     r_byte_bit  <= r_byte_bit + 3'd1;
                     r_cfg_value <= r_shift[1];
                  end else begin
                     r_state <= S_FETCH;
                     r_ready <= 1'b1;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign data_ready_o = r_ready;
   assign cfg_clk_o    = r_cfg_clk;
   assign cfg_value_o  = r_cfg_value;
   assign busy_o       = r_busy;
   assign done_o       = r_done;
   assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: instance A (5 bits, CLK_DIV=2) and
// instance B (20 bits, CLK_DIV=1) share clock and reset.
module tb_cfg_chain_loader;

   logic clk = 1'b0;
   logic rst;

   logic       st_a, ab_a, v_a, rdy_a, cc_a, cv_a, bsy_a, dn_a, ov_a;
   logic [7:0] d_a;
   logic       st_b, ab_b, v_b, rdy_b, cc_b, cv_b, bsy_b, dn_b, ov_b;
   logic [7:0] d_b;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cfg_chain_loader #(.NUM_BITS(5), .CLK_DIV(2)) u_a (
      .clk_i(clk), .rst_i(rst), .start_i(st_a), .abort_i(ab_a),
      .data_i(d_a), .data_valid_i(v_a), .data_ready_o(rdy_a),
      .cfg_clk_o(cc_a), .cfg_value_o(cv_a), .busy_o(bsy_a),
      .done_o(dn_a), .overflow_o(ov_a)
   );

   cfg_chain_loader #(.NUM_BITS(20), .CLK_DIV(1)) u_b (
      .clk_i(clk), .rst_i(rst), .start_i(st_b), .abort_i(ab_b),
      .data_i(d_b), .data_valid_i(v_b), .data_ready_o(rdy_b),
      .cfg_clk_o(cc_b), .cfg_value_o(cv_b), .busy_o(bsy_b),
      .done_o(dn_b), .overflow_o(ov_b)
   );

   // Chain observers: count cfg_clk rises, capture cfg_value at each rise,
   // and for instance A measure phase lengths in clk periods.
   logic prev_a = 1'b0, prev_b = 1'b0;
   int   rises_a = 0, rises_b = 0, len_a = 0, perr_a = 0;
   logic vals_a [0:255];
   logic vals_b [0:255];

   always @(negedge clk) begin
      prev_a <= cc_a;
      if (cc_a && !prev_a) begin
         if (rises_a < 256) vals_a[rises_a] <= cv_a;
         rises_a <= rises_a + 1;
         if (len_a < 2) perr_a <= perr_a + 1;
         len_a <= 1;
      end else if (!cc_a && prev_a) begin
         if (len_a != 2) perr_a <= perr_a + 1;
         len_a <= 1;
      end else begin
         len_a <= len_a + 1;
      end
   end

   always @(negedge clk) begin
      prev_b <= cc_b;
      if (cc_b && !prev_b) begin
         if (rises_b < 256) vals_b[rises_b] <= cv_b;
         rises_b <= rises_b + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start(input bit sel);
      if (sel) st_b = 1'b1; else st_a = 1'b1;
      @(posedge clk); #2;
      st_a = 1'b0;
      st_b = 1'b0;
   endtask

   task automatic send(input bit sel, input logic [7:0] b);
      logic r;
      int   n;
      n = 0;
      if (sel) begin d_b = b; v_b = 1'b1; end
      else     begin d_a = b; v_a = 1'b1; end
      do begin
         r = sel ? rdy_b : rdy_a;
         @(posedge clk); #2;
         n++;
      end while (!r && n < 200);
      v_a = 1'b0;
      v_b = 1'b0;
      chk("byte_accepted", 32'(r), 32'd1);
   endtask

   task automatic wait_done(input bit sel, input int budget);
      int n;
      n = 0;
      while (!(sel ? dn_b : dn_a) && n < budget) begin
         @(posedge clk); #2;
         n++;
      end
      chk("done_reached", 32'(sel ? dn_b : dn_a), 32'd1);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #2;
      end
   endtask

   function automatic logic [31:0] get_word(input bit sel, input int base, input int nbits);
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < nbits; k++) begin
         w[k] = sel ? vals_b[base + k] : vals_a[base + k];
      end
      return w;
   endfunction

   initial begin
      int base;
      int n;
      int stall_err;
      rst  = 1'b1;
      st_a = 1'b0; ab_a = 1'b0; v_a = 1'b0; d_a = '0;
      st_b = 1'b0; ab_b = 1'b0; v_b = 1'b0; d_b = '0;
      #3;
      chk("rst_outputs_a", {26'd0, rdy_a, cc_a, cv_a, bsy_a, dn_a, ov_a}, 32'd0);
      chk("rst_outputs_b", {26'd0, rdy_b, cc_b, cv_b, bsy_b, dn_b, ov_b}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      idle_cycles(3);
      chk("idle_no_ready_a", 32'(rdy_a), 32'd0);

      // A: 5-bit chain, byte 0x15 -> 1,0,1,0,1
      base = rises_a;
      pulse_start(1'b0);
      chk("start_ready_a", 32'(rdy_a), 32'd1);
      chk("start_busy_a", 32'(bsy_a), 32'd1);
      send(1'b0, 8'h15);
      wait_done(1'b0, 100);
      idle_cycles(1);
      chk("a1_rises", 32'(rises_a - base), 32'd5);
      chk("a1_bits", get_word(1'b0, base, 5), 32'h15);
      chk("a1_busy", 32'(bsy_a), 32'd0);
      chk("a1_idle_lines", {29'd0, cc_a, cv_a, rdy_a}, 32'd0);
      chk("a_phase_timing", 32'(perr_a), 32'd0);

      // A: byte offered in DONE sets sticky overflow
      d_a = 8'hEE; v_a = 1'b1;
      @(posedge clk); #2;
      v_a = 1'b0;
      chk("ovf_set", 32'(ov_a), 32'd1);
      idle_cycles(3);
      chk("ovf_sticky", 32'(ov_a), 32'd1);
      chk("ovf_done_kept", 32'(dn_a), 32'd1);

      // A: restart from DONE clears status; start mid-load is ignored
      base = rises_a;
      pulse_start(1'b0);
      chk("restart_ovf", 32'(ov_a), 32'd0);
      chk("restart_done", 32'(dn_a), 32'd0);
      chk("restart_ready", 32'(rdy_a), 32'd1);
      send(1'b0, 8'h0A);
      pulse_start(1'b0);
      wait_done(1'b0, 100);
      idle_cycles(1);
      chk("a2_rises", 32'(rises_a - base), 32'd5);
      chk("a2_bits", get_word(1'b0, base, 5), 32'h0A);
      chk("a_phase_timing2", 32'(perr_a), 32'd0);

      // B: 20 bits from A5,3C,F7 back-to-back
      base = rises_b;
      pulse_start(1'b1);
      send(1'b1, 8'hA5);
      send(1'b1, 8'h3C);
      send(1'b1, 8'hF7);
      wait_done(1'b1, 200);
      idle_cycles(2);
      chk("b1_rises", 32'(rises_b - base), 32'd20);
      chk("b1_bits", get_word(1'b1, base, 20), 32'h73CA5);
      chk("b1_busy", 32'(bsy_b), 32'd0);

      // B: start with abort in DONE -> start wins; then abort from FETCH
      st_b = 1'b1; ab_b = 1'b1;
      @(posedge clk); #2;
      st_b = 1'b0; ab_b = 1'b0;
      chk("start_over_abort_ready", 32'(rdy_b), 32'd1);
      chk("start_over_abort_done", 32'(dn_b), 32'd0);
      ab_b = 1'b1;
      @(posedge clk); #2;
      ab_b = 1'b0;
      chk("abort_fetch_idle", {29'd0, rdy_b, bsy_b, dn_b}, 32'd0);

      // B: 10-cycle stall between bytes 1 and 2
      base = rises_b;
      pulse_start(1'b1);
      send(1'b1, 8'h5A);
      n = 0;
      while (!rdy_b && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      chk("stall_fetch_reached", 32'(rdy_b), 32'd1);
      stall_err = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #2;
         if (cc_b !== 1'b0 || rdy_b !== 1'b1) stall_err++;
      end
      chk("stall_lines", 32'(stall_err), 32'd0);
      chk("stall_rises", 32'(rises_b - base), 32'd8);
      send(1'b1, 8'hC3);
      send(1'b1, 8'h09);
      wait_done(1'b1, 200);
      idle_cycles(2);
      chk("b2_rises", 32'(rises_b - base), 32'd20);
      chk("b2_bits", get_word(1'b1, base, 20), 32'h9C35A);

      // B: abort after 9 rises, then a fresh full load
      base = rises_b;
      pulse_start(1'b1);
      send(1'b1, 8'hFF);
      send(1'b1, 8'hFF);
      n = 0;
      while ((rises_b - base) < 9 && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      ab_b = 1'b1;
      @(posedge clk); #2;
      ab_b = 1'b0;
      chk("abort_clk", 32'(cc_b), 32'd0);
      chk("abort_status", {30'd0, bsy_b, dn_b}, 32'd0);
      idle_cycles(4);
      chk("abort_rises", 32'(rises_b - base), 32'd9);
      base = rises_b;
      pulse_start(1'b1);
      send(1'b1, 8'h11);
      send(1'b1, 8'h22);
      send(1'b1, 8'h03);
      wait_done(1'b1, 200);
      idle_cycles(2);
      chk("b3_rises", 32'(rises_b - base), 32'd20);
      chk("b3_bits", get_word(1'b1, base, 20), 32'h32211);

      // A: asynchronous reset during a high phase
      pulse_start(1'b0);
      send(1'b0, 8'hFF);
      n = 0;
      while (!cc_a && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      chk("hi_phase_reached", 32'(cc_a), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_lines", {29'd0, cc_a, bsy_a, rdy_a}, 32'd0);
      #2 rst = 1'b0;
      idle_cycles(5);
      chk("post_rst_a", {26'd0, rdy_a, cc_a, cv_a, bsy_a, dn_a, ov_a}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
